// File: rtl/imm_table.sv
// rtl/imm_table.sv - writable immediate-value table with default reload walk and write lock
//
// Purpose: DEPTH-entry table of DATA_W-bit immediates. Reset reloads the whole
// default table in one cycle; a restore request reloads it one entry per cycle
// while busy is high. Lookups have one cycle of latency and see same-cycle
// writes (write-first). Writes can be locked out until the next reset.
//
// Ports:
//   Clk, Reset_n         clock, synchronous active-low reset
//   rd_en, rd_index      lookup request and index
//   rd_value             registered lookup result, holds between lookups
//   rd_valid, rd_err     one-cycle result pulse, out-of-range lookup pulse
//   wr_en, wr_index,
//   wr_data              table write request
//   wr_err               one-cycle pulse, write rejected
//   lock, locked         sticky write protect request / status
//   restore, busy        default reload request / walk in progress

module imm_table #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 32,
  parameter int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              rd_en,
  input  logic [IDX_W-1:0]  rd_index,
  output logic [DATA_W-1:0] rd_value,
  output logic              rd_valid,
  output logic              rd_err,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_index,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_err,
  input  logic              lock,
  output logic              locked,
  input  logic              restore,
  output logic              busy
);

  typedef enum logic {S_IDLE, S_RESTORE} state_t;

  // One bit wider than the index so DEPTH itself is representable (DEPTH=256).
  localparam logic [IDX_W:0]   DEPTH_L  = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_PTR = IDX_W'(DEPTH - 1);

  // Default contents; truncated or zero-extended to DATA_W by the cast.
  function automatic logic [DATA_W-1:0] def_entry(input int i);
    logic [7:0] v;
    case (i)
      0: v = 8'd0;     1: v = 8'd1;     2: v = 8'd2;     3: v = 8'd3;
      4: v = 8'd4;     5: v = 8'd5;     6: v = 8'd6;     7: v = 8'd14;
      8: v = 8'd16;    9: v = 8'd30;    10: v = 8'd31;   11: v = 8'd32;
      12: v = 8'd33;   13: v = 8'd60;   14: v = 8'd91;   15: v = 8'd109;
      16: v = 8'd142;  17: v = 8'd170;  18: v = 8'd204;  19: v = 8'd224;
      20: v = 8'd225;  21: v = 8'd240;  22: v = 8'd247;  23: v = 8'd254;
      24: v = 8'd85;
      default: v = 8'd0;
    endcase
    return DATA_W'(v);
  endfunction

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic               locked_q, locked_d;
  logic [DATA_W-1:0]  mem_q [DEPTH];
  logic [DATA_W-1:0]  mem_d [DEPTH];
  logic [DATA_W-1:0]  rd_value_q, rd_value_d;
  logic               rd_valid_q, rd_valid_d;
  logic               rd_err_q, rd_err_d;
  logic               wr_err_q, wr_err_d;

  logic busy_w;
  logic rd_in_range;
  logic wr_in_range;
  logic wr_ok;

  assign busy_w      = (state_q == S_RESTORE);
  assign rd_in_range = ({1'b0, rd_index} < DEPTH_L);
  assign wr_in_range = ({1'b0, wr_index} < DEPTH_L);
  assign wr_ok       = wr_en && !busy_w && !locked_q && wr_in_range;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    locked_d   = locked_q | lock;
    mem_d      = mem_q;
    rd_value_d = rd_value_q;
    rd_valid_d = 1'b0;
    rd_err_d   = 1'b0;
    wr_err_d   = wr_en && !wr_ok;

    if (rd_en && !busy_w) begin
      rd_valid_d = 1'b1;
      if (!rd_in_range) begin
        rd_err_d   = 1'b1;
        rd_value_d = '0;
      end else if (wr_ok && (wr_index == rd_index)) begin
        rd_value_d = wr_data;
      end else begin
        rd_value_d = mem_q[rd_index];
      end
    end

    // Writes are rejected while busy, so the walk and a write never collide.
    if (wr_ok) begin
      mem_d[wr_index] = wr_data;
    end

    case (state_q)
      S_IDLE: begin
        if (restore) begin
          state_d = S_RESTORE;
          ptr_d   = '0;
        end
      end
      S_RESTORE: begin
        mem_d[ptr_q] = def_entry(int'(ptr_q));
        if (ptr_q == LAST_PTR) begin
          state_d = S_IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + IDX_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      locked_q   <= 1'b0;
      rd_value_q <= '0;
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
      wr_err_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= def_entry(i);
      end
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      locked_q   <= locked_d;
      rd_value_q <= rd_value_d;
      rd_valid_q <= rd_valid_d;
      rd_err_q   <= rd_err_d;
      wr_err_q   <= wr_err_d;
      mem_q      <= mem_d;
    end
  end

  assign rd_value = rd_value_q;
  assign rd_valid = rd_valid_q;
  assign rd_err   = rd_err_q;
  assign wr_err   = wr_err_q;
  assign locked   = locked_q;
  assign busy     = busy_w;

endmodule
